// File: rtl/instr_encode_loader.sv
// Packs opcode/dest/src/imm field sets into instruction words, buffers them in
// a small FIFO and writes them sequentially into instruction memory.
module instr_encode_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [3:0]            in_dest,
  input  logic [3:0]            in_src,
  input  logic [7:0]            in_imm,
  input  logic                  in_use_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]         PTR_ONE  = (PW+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] encode_word(
    input logic [3:0] op,
    input logic [3:0] dest,
    input logic [3:0] src,
    input logic [7:0] imm,
    input logic       use_imm
  );
    logic [DATA_WIDTH-1:0] w;
    w        = '0;
    w[15:12] = op;
    w[11:8]  = dest;
    if (use_imm) begin
      w[7:0] = imm;
    end else begin
      w[7:4] = src;
      w[3:0] = 4'h0;
    end
    return w;
  endfunction

  state_t                  state_q, state_d;
  logic [PW:0]             wr_ptr_q, wr_ptr_d;
  logic [PW:0]             rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

  logic                    full_s, empty_s, push_s, pop_s;
  logic [PW:0]             occ_s;
  logic [DATA_WIDTH-1:0]   enc_s;

  // FIFO status and handshake qualifiers; no bypass, so a full FIFO blocks input
  always_comb begin
    occ_s   = wr_ptr_q - rd_ptr_q;
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
              (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    push_s  = (state_q == LOAD) && in_valid && !full_s;
    pop_s   = (state_q != IDLE) && !empty_s && mem_ready;
    enc_s   = encode_word(in_opcode, in_dest, in_src, in_imm, in_use_imm);
  end

  // Next-state logic for the session FSM, write address and counters
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    wr_ptr_d = wr_ptr_q + (push_s ? PTR_ONE : '0);
    rd_ptr_d = rd_ptr_q + (pop_s ? PTR_ONE : '0);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = base_addr;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (push_s && in_last) begin
          state_d = DRAIN;
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        // leave on the edge that retires the last buffered word
        if (empty_s || (pop_s && (occ_s == PTR_ONE))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (pop_s) begin
      addr_d = addr_q + ADDR_ONE;
      cnt_d  = cnt_q + CNT_ONE;
      if (addr_q == {ADDR_WIDTH{1'b1}}) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      addr_d = addr_d;
    end
  end

  // State and control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Word storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q[PW-1:0]] <= enc_s;
    end
  end

  assign in_ready   = (state_q == LOAD) && !full_s;
  assign mem_we     = (state_q != IDLE) && !empty_s;
  assign mem_addr   = addr_q;
  assign mem_wdata  = fifo_mem[rd_ptr_q[PW-1:0]];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: table of field sets with hand-encoded
// words, plus sequences for backpressure, wrap, ignored start and mid-session reset.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = 4'h0;
  logic [3:0]  in_dest = 4'h0;
  logic [3:0]  in_src = 4'h0;
  logic [7:0]  in_imm = 8'h00;
  logic        in_use_imm = 1'b0;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [8:0]  word_count;

  instr_encode_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dest(in_dest), .in_src(in_src), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [7:0]  imm;
    logic        use_imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] dst;
    logic [3:0] src;
    logic [7:0] imm;
    logic       use_imm;
    logic       last;
  } fs_t;

  vec_t tbl [8];
  fs_t  src_q [$];
  logic [7:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q [$];
  int          acc_cyc_q [$];
  int          cyc = 0;
  int          acc_cnt = 0;
  int          done_cyc = 0;
  bit          xfer_n = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: completed writes and accepted transfers, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    xfer_n = in_valid && in_ready && rst_n;
    if (mem_we && mem_ready && rst_n) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (xfer_n) begin
      acc_cnt++;
      acc_cyc_q.push_back(cyc);
    end
  end

  // Source: holds each field set until it is accepted
  initial forever begin
    @(posedge clk);
    #1;
    if (xfer_n && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0) begin
      in_valid   = 1'b1;
      in_opcode  = src_q[0].op;
      in_dest    = src_q[0].dst;
      in_src     = src_q[0].src;
      in_imm     = src_q[0].imm;
      in_use_imm = src_q[0].use_imm;
      in_last    = src_q[0].last;
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int first, input int n);
    fs_t f;
    for (int i = 0; i < n; i++) begin
      f.op      = tbl[(first + i) % 8].op;
      f.dst     = tbl[(first + i) % 8].dst;
      f.src     = tbl[(first + i) % 8].src;
      f.imm     = tbl[(first + i) % 8].imm;
      f.use_imm = tbl[(first + i) % 8].use_imm;
      f.last    = (i == n - 1);
      src_q.push_back(f);
    end
  endtask

  task automatic start_session(input logic [7:0] base);
    tick();
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        got      = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic check_writes(input logic [7:0] base, input int first, input int n);
    logic [7:0] ea;
    check("write_count", wr_addr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (wr_addr_q.size() == 0) break;
      ea = base + i[7:0];
      check($sformatf("waddr[%0d]", i), {24'd0, wr_addr_q.pop_front()}, {24'd0, ea});
      check($sformatf("wdata[%0d]", i), wr_data_q.pop_front(), tbl[(first + i) % 8].exp);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_word_count"}, {23'd0, word_count}, 32'd0);
  endtask

  initial begin
    int c0;
    int acc0;
    bit ok;
    logic [7:0]  a_hold;
    logic [31:0] d_hold;

    //            op     dst    src    imm     imm?  encoded word
    tbl[0] = '{4'h3, 4'h5, 4'hA, 8'h00, 1'b0, 32'h0000_35A0};
    tbl[1] = '{4'h1, 4'h2, 4'h0, 8'h7F, 1'b1, 32'h0000_127F};
    tbl[2] = '{4'hF, 4'hF, 4'hF, 8'hFF, 1'b0, 32'h0000_FFF0};
    tbl[3] = '{4'h0, 4'h0, 4'h0, 8'h00, 1'b1, 32'h0000_0000};
    tbl[4] = '{4'hA, 4'h3, 4'h6, 8'h55, 1'b0, 32'h0000_A360};
    tbl[5] = '{4'h7, 4'hC, 4'h0, 8'h81, 1'b1, 32'h0000_7C81};
    tbl[6] = '{4'h2, 4'h4, 4'h9, 8'h3C, 1'b1, 32'h0000_243C};
    tbl[7] = '{4'h5, 4'h9, 4'h0, 8'hAB, 1'b0, 32'h0000_5900};

    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_vals("reset");
    tick();
    rst_n = 1'b1;

    // Encode: two words, then the rest of the table as a second session
    mem_ready = 1'b1;
    load(0, 2);
    start_session(8'h10);
    wait_done();
    check("encA_word_count", {23'd0, word_count}, 32'd2);
    check_writes(8'h10, 0, 2);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    load(2, 6);
    start_session(8'h20);
    wait_done();
    check("encB_word_count", {23'd0, word_count}, 32'd6);
    check_writes(8'h20, 2, 6);

    // Throughput: 16 words back to back
    acc_cyc_q.delete();
    load(0, 16);
    start_session(8'h80);
    wait_done();
    c0 = (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : 0;
    check("tp_writes", wr_cyc_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i >= wr_cyc_q.size()) break;
      check($sformatf("tp_cycle[%0d]", i), wr_cyc_q[i], c0 + 1 + i);
    end
    check("tp_done_cycle", done_cyc, c0 + 17);
    check("tp_word_count", {23'd0, word_count}, 32'd16);
    check_writes(8'h80, 0, 16);

    // Backpressure: memory stalled for 8 cycles, 6 words offered
    mem_ready = 1'b0;
    acc0 = acc_cnt;
    load(3, 6);
    start_session(8'h50);
    @(negedge clk);
    @(negedge clk);
    check("bp_we_early", {31'd0, mem_we}, 32'd1);
    a_hold = mem_addr;
    d_hold = mem_wdata;
    check("bp_addr_early", {24'd0, a_hold}, 32'h50);
    check("bp_data_early", d_hold, tbl[3].exp);
    repeat (6) @(negedge clk);
    check("bp_accepted", acc_cnt - acc0, 4);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_addr_stable", {24'd0, mem_addr}, {24'd0, a_hold});
    check("bp_data_stable", mem_wdata, d_hold);
    tick();
    mem_ready = 1'b1;
    wait_done();
    check("bp_word_count", {23'd0, word_count}, 32'd6);
    check_writes(8'h50, 3, 6);

    // Wrap past the top of the address space
    load(5, 3);
    start_session(8'hFE);
    wait_done();
    check("wrap_overflow", {31'd0, overflow}, 32'd1);
    check("wrap_mem_addr", {24'd0, mem_addr}, 32'h01);
    check_writes(8'hFE, 5, 3);

    // start during LOAD is ignored; new start clears overflow
    mem_ready = 1'b0;
    load(1, 5);
    start_session(8'h30);
    @(negedge clk);
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    check("ign_busy", {31'd0, busy}, 32'd1);
    start     = 1'b1;
    base_addr = 8'h40;
    tick();
    start     = 1'b0;
    repeat (2) @(negedge clk);
    check("ign_addr", {24'd0, mem_addr}, 32'h30);
    tick();
    mem_ready = 1'b1;
    wait_done();
    check_writes(8'h30, 1, 5);

    // Reset mid-DRAIN with three words buffered
    mem_ready = 1'b0;
    acc0 = acc_cnt;
    load(4, 3);
    start_session(8'h60);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (acc_cnt - acc0 >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_words_buffered", {31'd0, ok}, 32'd1);
    tick();
    @(negedge clk);
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    check("rst_pre_we", {31'd0, mem_we}, 32'd1);
    tick();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("midrst_we_low[%0d]", k), {31'd0, mem_we}, 32'd0);
    end
    check("midrst_no_writes", wr_addr_q.size(), 0);

    // Fresh session after reset still works
    load(6, 2);
    start_session(8'h70);
    wait_done();
    check_writes(8'h70, 6, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
